// File: rtl/clock_pkg.sv
// Shared types and BCD helpers for the digital clock counter stages.
// bcd2_inc is also used by the hours counter.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET      = 2'd1,
        SET_HOLD = 2'd2
    } state_t;

    localparam int BCD_W = 4;

    // Advance a packed two-digit BCD value, wrapping to 00 after modulus-1.
    function automatic logic [2*BCD_W-1:0] bcd2_inc(input logic [2*BCD_W-1:0] value,
                                                    input int modulus);
        logic [BCD_W-1:0] tens;
        logic [BCD_W-1:0] ones;
        logic [BCD_W-1:0] last_tens;
        logic [BCD_W-1:0] last_ones;
        tens      = value[2*BCD_W-1:BCD_W];
        ones      = value[BCD_W-1:0];
        last_tens = BCD_W'((modulus - 1) / 10);
        last_ones = BCD_W'((modulus - 1) % 10);
        if (tens == last_tens && ones == last_ones)
            return '0;
        if (ones == BCD_W'(9))
            return {tens + BCD_W'(1), BCD_W'(0)};
        return {tens, ones + BCD_W'(1)};
    endfunction

endpackage

// File: rtl/key_repeat.sv
// Increment-button handling for set mode: edge detect on inc plus an
// auto-repeat timer, producing a one-cycle step request.
module key_repeat #(
    parameter int REPEAT_DLY = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic armed,
    input  logic in_set,
    input  logic in_hold,
    input  logic inc,
    output logic step,
    output logic rise
);
    localparam int CW = (REPEAT_DLY > 1) ? $clog2(REPEAT_DLY) : 1;
    localparam logic [CW-1:0] LAST = CW'(REPEAT_DLY - 1);

    logic          inc_q;
    logic [CW-1:0] hold_cnt;

    assign rise = inc & ~inc_q;

    always_comb begin
        step = 1'b0;
        if (armed && in_set && rise)
            step = 1'b1;
        else if (armed && in_hold && inc && hold_cnt == LAST)
            step = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inc_q    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            inc_q <= inc;
            if (armed && in_set && rise)
                hold_cnt <= '0;
            else if (armed && in_hold && inc)
                hold_cnt <= (hold_cnt == LAST) ? '0 : hold_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mod60_counter.sv
// BCD seconds/minutes stage with run/set modes and a carry to the next stage.
//   state    | meaning
//   RUN      | count on en_in, carry out at MODULUS-1
//   SET      | waiting for an inc press; en_in ignored
//   SET_HOLD | inc held; auto-repeat every REPEAT_DLY cycles
module mod60_counter
    import clock_pkg::*;
#(
    parameter int MODULUS    = 60,
    parameter int REPEAT_DLY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_in,
    input  logic       key,
    input  logic       inc,
    output logic [7:0] out,
    output logic       en_out,
    output logic       set_mode
);
    localparam logic [7:0] LAST = {4'((MODULUS - 1) / 10), 4'((MODULUS - 1) % 10)};

    state_t state;
    logic   step;
    logic   rise;

    key_repeat #(
        .REPEAT_DLY(REPEAT_DLY)
    ) u_key_repeat (
        .clk    (clk),
        .rst    (rst),
        .armed  (~key),
        .in_set (state == SET),
        .in_hold(state == SET_HOLD),
        .inc    (inc),
        .step   (step),
        .rise   (rise)
    );

    // Zero-lag carry: the next stage advances on the same edge this one wraps.
    assign en_out = en_in & (state == RUN) & (out == LAST) & rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            out      <= 8'h00;
            set_mode <= 1'b0;
        end else begin
            if ((state == RUN && en_in) || step)
                out <= bcd2_inc(out, MODULUS);

            if (key) begin
                state    <= RUN;
                set_mode <= 1'b0;
            end else begin
                set_mode <= 1'b1;
                case (state)
                    RUN:      state <= SET;
                    SET:      state <= rise ? SET_HOLD : SET;
                    SET_HOLD: state <= inc ? SET_HOLD : SET;
                    default:  state <= SET;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mod60_counter.sv
// Bench for mod60_counter: directed vector tables plus randomized traffic
// against an integer-count reference model.
module tb_mod60_counter;
    localparam int MOD = 60;
    localparam int DLY = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key = 1'b1;
    logic       en_in = 1'b0;
    logic       inc = 1'b0;
    logic [7:0] out;
    logic       en_out;
    logic       set_mode;

    int checks = 0;
    int errors = 0;

    // Reference model: count as plain integer, mode 0=run 1=set 2=set-hold.
    int m_cnt  = 0;
    int m_mode = 0;
    int m_hold = 0;
    bit m_incq = 1'b0;

    typedef struct {
        bit         r;
        bit         k;
        bit         e;
        bit         i;
        logic [7:0] out;
        bit         en;
        bit         sm;
    } vec_t;

    vec_t vq[$];

    mod60_counter #(
        .MODULUS   (MOD),
        .REPEAT_DLY(DLY)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en_in   (en_in),
        .key     (key),
        .inc     (inc),
        .out     (out),
        .en_out  (en_out),
        .set_mode(set_mode)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] t;
        logic [3:0] o;
        t = 4'(v / 10);
        o = 4'(v % 10);
        return {t, o};
    endfunction

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit k, input bit e, input bit i);
        bit stepped;
        int nmode;
        if (!r) begin
            m_cnt = 0; m_mode = 0; m_hold = 0; m_incq = 1'b0;
            return;
        end
        stepped = 1'b0;
        if (m_mode == 0 && e) stepped = 1'b1;
        if (m_mode == 1 && !k && i && !m_incq) begin
            stepped = 1'b1;
            m_hold  = 0;
        end
        if (m_mode == 2 && !k && i) begin
            if (m_hold == DLY - 1) begin
                stepped = 1'b1;
                m_hold  = 0;
            end else begin
                m_hold = m_hold + 1;
            end
        end
        if (k) nmode = 0;
        else if (m_mode == 0) nmode = 1;
        else if (m_mode == 1) nmode = (i && !m_incq) ? 2 : 1;
        else nmode = i ? 2 : 1;
        if (stepped) m_cnt = (m_cnt + 1) % MOD;
        m_mode = nmode;
        m_incq = i;
    endtask

    // One clock: drive, check carry before the edge, advance model, check state after.
    task automatic cycle(input bit r, input bit k, input bit e, input bit i, input string nm,
                         input bit tbl, input logic [7:0] t_out, input bit t_en, input bit t_sm);
        bit exp_en;
        rst = r; key = k; en_in = e; inc = i;
        #3;
        exp_en = e && (m_mode == 0) && (m_cnt == MOD - 1) && r;
        check1({nm, " en_out"}, en_out, exp_en);
        if (tbl) check1({nm, " en_out(tbl)"}, en_out, t_en);
        @(posedge clk);
        model_edge(r, k, e, i);
        #1;
        check8({nm, " out"}, out, to_bcd(m_cnt));
        check1({nm, " set_mode"}, set_mode, m_mode != 0);
        if (tbl) begin
            check8({nm, " out(tbl)"}, out, t_out);
            check1({nm, " set_mode(tbl)"}, set_mode, t_sm);
        end
    endtask

    task automatic add(input bit r, input bit k, input bit e, input bit i,
                       input logic [7:0] o, input bit en, input bit sm);
        vec_t v;
        v.r = r; v.k = k; v.e = e; v.i = i; v.out = o; v.en = en; v.sm = sm;
        vq.push_back(v);
    endtask

    task automatic run_table(input string nm);
        foreach (vq[n])
            cycle(vq[n].r, vq[n].k, vq[n].e, vq[n].i, $sformatf("%s[%0d]", nm, n),
                  1'b1, vq[n].out, vq[n].en, vq[n].sm);
        vq.delete();
    endtask

    task automatic count_run(input int n, input string nm);
        for (int c = 0; c < n; c++) cycle(1, 1, 1, 0, nm, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        bit rk;
        bit ri;
        cycle(0, 1, 1, 0, "init_reset", 1'b0, 8'h00, 1'b0, 1'b0);
        count_run(37, "run_to_37");
        check8("preset_37", out, 8'h37);

        add(0, 1, 1, 0, 8'h00, 0, 0);
        add(0, 1, 1, 0, 8'h00, 0, 0);
        run_table("reset");

        for (int c = 0; c < 60; c++) begin
            cycle(1, 1, 1, 0, "full_count", 1'b0, 8'h00, 1'b0, 1'b0);
            checks++;
            if (out[3:0] > 4'd9 || out[7:4] > 4'd5) begin
                errors++;
                $display("FAIL full_count bcd: got %h required valid BCD below 60", out);
            end
        end
        check8("full_count_wrap", out, 8'h00);

        count_run(58, "run_to_58a");
        add(1, 1, 1, 0, 8'h59, 0, 0);
        add(1, 1, 0, 0, 8'h59, 0, 0);
        add(1, 1, 0, 0, 8'h59, 0, 0);
        add(1, 1, 1, 0, 8'h00, 1, 0);
        run_table("gating");

        count_run(58, "run_to_58b");
        add(1, 0, 0, 0, 8'h58, 0, 1);
        add(1, 0, 1, 1, 8'h59, 0, 1);
        add(1, 0, 1, 0, 8'h59, 0, 1);
        add(1, 0, 1, 0, 8'h59, 0, 1);
        add(1, 0, 1, 0, 8'h59, 0, 1);
        add(1, 0, 1, 1, 8'h00, 0, 1);
        add(1, 0, 1, 0, 8'h00, 0, 1);
        run_table("set_single");

        add(1, 0, 0, 1, 8'h01, 0, 1);
        add(1, 0, 0, 1, 8'h01, 0, 1);
        add(1, 0, 0, 1, 8'h02, 0, 1);
        add(1, 0, 0, 1, 8'h02, 0, 1);
        add(1, 0, 0, 1, 8'h03, 0, 1);
        add(1, 0, 0, 1, 8'h03, 0, 1);
        add(1, 0, 0, 1, 8'h04, 0, 1);
        add(1, 0, 0, 0, 8'h04, 0, 1);
        run_table("auto_repeat");

        add(1, 0, 0, 1, 8'h05, 0, 1);
        add(1, 0, 0, 1, 8'h05, 0, 1);
        add(1, 1, 1, 1, 8'h05, 0, 0);
        add(1, 1, 1, 0, 8'h06, 0, 0);
        add(1, 1, 1, 0, 8'h07, 0, 0);
        run_table("exit_hold");

        add(1, 0, 0, 0, 8'h07, 0, 1);
        add(1, 0, 0, 1, 8'h08, 0, 1);
        add(1, 0, 0, 1, 8'h08, 0, 1);
        add(0, 0, 0, 1, 8'h00, 0, 0);
        add(1, 1, 0, 0, 8'h00, 0, 0);
        add(1, 1, 1, 0, 8'h01, 0, 0);
        run_table("reset_hold");

        add(1, 0, 1, 0, 8'h02, 0, 1);
        add(1, 0, 1, 0, 8'h02, 0, 1);
        add(1, 1, 0, 0, 8'h02, 0, 0);
        run_table("key_and_en");

        rk = 1'b1;
        ri = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 11) == 0) rk = ~rk;
            if ($urandom_range(0, 3) == 0) ri = ~ri;
            cycle($urandom_range(0, 79) != 0, rk, $urandom_range(0, 3) != 0, ri,
                  "random", 1'b0, 8'h00, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod60_counter.md
Name: mod60_counter

Overview:
- BCD minutes/seconds stage of the digital clock. Two instances are chained: seconds then minutes.
- The minutes instance's en_out drives the hours counter's clock enable. That makes this block the direct upstream feeder of the hours stage.
- Counts 00..MODULUS-1 in packed 2-digit BCD and issues a carry at wrap.
- Supports a key-driven set mode with a single-step and auto-repeat increment button.

Parameters:
- MODULUS, 60, count range 00..MODULUS-1. Legal range 2..100.
- REPEAT_DLY, 2, cycles per auto-repeat step while inc is held in set mode. Must be at least 1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-low reset.
- en_in  input  1  count enable / carry-in from the previous stage. Tie to 1 for the seconds stage.
- key  input  1  mode select: 1 = run, 0 = set.
- inc  input  1  increment button, level, active-high, already synchronised.
- out  output  8  packed BCD count: {tens[3:0], ones[3:0]}.
- en_out  output  1  carry to the next stage, combinational.
- set_mode  output  1  high while in SET or SET_HOLD, registered.

Behaviour:
- Reset: rst=0 at a posedge sets out=8'h00, state=RUN, hold_cnt=0, inc_q=0. This takes priority over every other input.
  - en_out=0 and set_mode=0 throughout the reset cycle.
- BCD step rule:
  - ones==9 gives ones=0, tens+1.
  - A value equal to MODULUS-1 (BCD) wraps to 00.
  - out is always valid BCD; there is no load path.
- FSM states are RUN, SET and SET_HOLD.
  - Next state from any state: key=0 selects set states, key=1 selects RUN.
  - Actions are taken on the current (registered) state.
- RUN:
  - en_in=1 steps out by one at the edge; en_in=0 holds.
  - inc is ignored.
  - key=0 moves to SET.
- en_out = en_in & (state==RUN) & (out==MODULUS-1) & rst.
  - It is a single-cycle pulse when en_in is a pulse. The downstream stage increments at the same edge this stage wraps (zero lag).
- SET:
  - en_in is ignored and en_out=0.
  - A rising edge of inc (inc & ~inc_q) steps out once, clears hold_cnt and moves to SET_HOLD.
  - A wrap in set mode never produces en_out.
- SET_HOLD, while inc=1:
  - if hold_cnt==REPEAT_DLY-1, step out and clear hold_cnt;
  - otherwise hold_cnt+1.
  - inc=0 returns to SET with no step.
- key=1 from SET or SET_HOLD moves to RUN at that edge with no step. Counting resumes on following edges.
- Simultaneous key=0 and en_in=1 while in RUN: the step still occurs at that edge (the current state is RUN); set mode applies from the next edge.
- Reset mid-operation (during SET_HOLD or during a carry) clears everything; no partial step.
- inc_q is updated every cycle.

Decomposition:
- Shared package clock_pkg holds:
  - the state enum {RUN, SET, SET_HOLD};
  - the BCD digit width constant (4);
  - the bcd2_inc(value, modulus) function, shared with the hours counter.
- One sub-module, key_repeat: inc edge detect plus hold_cnt. It emits a one-cycle step pulse and is parameterised by REPEAT_DLY.

Test Plan:
- Reset (key=1, en_in=1): hold rst=0 for 2 edges with out previously at 8'h37 -> out=8'h00, en_out=0, set_mode=0 after the first edge.
- Full count (rst=1, key=1, en_in=1): 60 edges from 00 -> sequence 01..09,10..59,00.
  - 09->10 correct; no hex values 0A-0F ever appear.
  - en_out=1 only in the cycle where out=59.
- Gating (en_in pattern 1,0,0,1 at out=58) -> out 59, 59, 59, 00.
  - en_out=0 while en_in=0; en_out=1 in the final en_in=1 cycle at 59.
- Set single step (key=0, en_in=1, out=58): two 1-cycle inc pulses separated by 3 idle cycles -> out 59 then 00.
  - en_out stays 0; set_mode=1; en_in has no effect.
- Auto-repeat (REPEAT_DLY=2, key=0, out=00, inc held 7 edges) -> steps at edges 1, 3, 5, 7, giving out=04.
  - inc then low -> out holds 04, state SET.
- Exit and reset mid-hold:
  - Case 1: in SET_HOLD, key=1 with en_in=1 -> no step at the exit edge, then counts +1 per edge; set_mode=0.
  - Case 2: repeat, but assert rst=0 instead -> out=00, RUN.
